if_bram_reader: RTL

IF_BRAM_READER -- requirements
Module: if_bram_reader

---
 rtl/if_bram_pkg.sv | 18 +
 rtl/if_bram_rd_fifo.sv | 76 +++++++
 rtl/if_bram_reader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/if_bram_pkg.sv
// Shared definitions for the if_bram family: default geometry of the BRAM, its read
// latency, the reader's output buffer depth, and the reader state encoding.
package if_bram_pkg;

   localparam int RAM_WIDTH_DEF  = 40;
   localparam int RAM_DEPTH_DEF  = 205;
   localparam int ADDR_W_DEF     = $clog2(RAM_DEPTH_DEF - 1);
   localparam int RD_LAT         = 2;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/if_bram_rd_fifo.sv
// Small synchronous FIFO holding BRAM read words plus their end-of-burst flag.
// The head word is presented combinationally and forced to zero while empty.
module if_bram_rd_fifo #(
   parameter int  WIDTH = 40,
   parameter int  DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clka,
   input  logic             rstb,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_last,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_last,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DEPTH - 1);

   logic [WIDTH:0]   mem_q [DEPTH];
   logic [WIDTH:0]   head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head    = mem_q[rd_ptr_q];
   assign rd_data = empty ? '0 : head[WIDTH-1:0];
   assign rd_last = ~empty & head[WIDTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_TOP) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_TOP) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clka) begin
      if (rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clka) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= {push_last, push_data};
      end
   end

endmodule

// File: rtl/if_bram_reader.sv
// Burst reader for a 2-cycle-latency BRAM: issues reads only when the output buffer can
// absorb them, and streams the words out as valid/ready with a last-word marker.
module if_bram_reader
   import if_bram_pkg::*;
#(
   parameter int  RAM_WIDTH  = RAM_WIDTH_DEF,
   parameter int  RAM_DEPTH  = RAM_DEPTH_DEF,
   parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int ADDR_W     = $clog2(RAM_DEPTH - 1),
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clka,
   input  logic                 rstb,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W-1:0]    len,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    bram_addr,
   output logic                 bram_en,
   output logic                 bram_we,
   output logic                 bram_regce,
   output logic                 bram_rst,
   input  logic [RAM_WIDTH-1:0] bram_dout,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last
);

   localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(RAM_DEPTH - 1);

   rd_state_e            state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0]    ptr_q, ptr_d, addr_q, addr_d;
   logic [ADDR_W:0]      remain_q, remain_d, len_eff;
   logic                 en_q, en_d, en_last_q, en_last_d;
   logic                 vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
   logic                 vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
   logic [CNT_W-1:0]     fifo_count;
   logic                 fifo_full, fifo_empty, fifo_last, pop;
   logic [RAM_WIDTH-1:0] fifo_data;
   int                   occ;

   assign len_eff = ({1'b0, len} > LEN_MAX) ? LEN_MAX : {1'b0, len};
   assign pop     = ~fifo_empty & m_ready;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      en_d      = 1'b0;
      en_last_d = 1'b0;
      // p1: read address registered inside the BRAM, output register enabled next
      vld_p1_d  = en_q;
      last_p1_d = en_last_q;
      // p2: word present on bram_dout, captured into the FIFO
      vld_p2_d  = vld_p1_q;
      last_p2_d = last_p1_q;

      // Words already committed to the FIFO, counting the one leaving this cycle.
      occ = int'(en_q) + int'(vld_p1_q) + int'(vld_p2_q) + int'(fifo_count) - int'(pop);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len_eff == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_ISSUE;
                  ptr_d    = base_addr;
                  remain_d = len_eff;
               end
            end
         end
         ST_ISSUE: begin
            if ((remain_q != '0) && (occ < FIFO_DEPTH) && !(fifo_full && !pop)) begin
               en_d      = 1'b1;
               en_last_d = (remain_q == (ADDR_W + 1)'(1));
               addr_d    = ptr_q;
               ptr_d     = (ptr_q == ADDR_TOP) ? '0 : ptr_q + ADDR_W'(1);
               remain_d  = remain_q - (ADDR_W + 1)'(1);
               if (remain_q == (ADDR_W + 1)'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && fifo_last) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clka) begin
      if (rstb) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ptr_q     <= '0;
         addr_q    <= '0;
         remain_q  <= '0;
         en_q      <= 1'b0;
         en_last_q <= 1'b0;
         vld_p1_q  <= 1'b0;
         last_p1_q <= 1'b0;
         vld_p2_q  <= 1'b0;
         last_p2_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ptr_q     <= ptr_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         en_q      <= en_d;
         en_last_q <= en_last_d;
         vld_p1_q  <= vld_p1_d;
         last_p1_q <= last_p1_d;
         vld_p2_q  <= vld_p2_d;
         last_p2_q <= last_p2_d;
      end
   end

   if_bram_rd_fifo #(
      .WIDTH (RAM_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clka      (clka),
      .rstb      (rstb),
      .push      (vld_p2_q),
      .push_data (bram_dout),
      .push_last (last_p2_q),
      .pop       (pop),
      .rd_data   (fifo_data),
      .rd_last   (fifo_last),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign busy       = busy_q;
   assign done       = done_q;
   assign bram_addr  = addr_q;
   assign bram_en    = en_q;
   assign bram_we    = 1'b0;
   assign bram_regce = vld_p1_q;
   assign bram_rst   = rstb;
   assign m_data     = fifo_data;
   assign m_valid    = ~fifo_empty;
   assign m_last     = fifo_last;

endmodule
